// File: rtl/rc4_pkg.sv
// Shared RC4 definitions used by the KSA, the i-index counter and the PRGA engine.
//   BYTE_W       : datapath width of S-box entries and indices
//   SBOX_DEPTH   : number of S-box entries
//   prga_state_t : PRGA sequencer states, one S-box access per state
package rc4_pkg;

   localparam int unsigned BYTE_W     = 8;
   localparam int unsigned SBOX_DEPTH = 256;
   localparam int unsigned ADDR_W     = $clog2(SBOX_DEPTH);

   typedef enum logic [3:0] {
      PRGA_IDLE  = 4'd0,
      PRGA_ADV   = 4'd1,
      PRGA_RD_SI = 4'd2,
      PRGA_LD_SI = 4'd3,
      PRGA_RD_SJ = 4'd4,
      PRGA_LD_SJ = 4'd5,
      PRGA_WR_I  = 4'd6,
      PRGA_WR_J  = 4'd7,
      PRGA_RD_K  = 4'd8,
      PRGA_LD_K  = 4'd9,
      PRGA_XFER  = 4'd10,
      PRGA_HOLD  = 4'd11,
      PRGA_DONE  = 4'd12
   } prga_state_t;

endpackage

// File: rtl/rc4_prga_engine.sv
// RC4 PRGA stage: per message byte advances the external i counter, updates j,
// swaps S[i]/S[j] in the external S-box SRAM, reads K = S[S[i]+S[j]] and emits
// plain = cipher ^ K over a valid/ready pair.
// Ports:
//   clk, n_rst                 clock (rising edge), async active-low reset
//   start, msg_len             message request, length latched on accepted start
//   busy, done                 engine activity, one-cycle completion pulse
//   i_val, i_advance, i_clear  external i-index counter interface
//   sbox_addr/we/wdata/rdata   S-box SRAM port (synchronous read, 1-cycle latency)
//   cipher_valid/data/ready    ciphertext input stream
//   plain_valid/data/ready     plaintext output stream
module rc4_prga_engine
   import rc4_pkg::*;
#(
   parameter int unsigned LEN_W = 16
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  msg_len,
   output logic              busy,
   output logic              done,
   input  logic [BYTE_W-1:0] i_val,
   output logic              i_advance,
   output logic              i_clear,
   output logic [ADDR_W-1:0] sbox_addr,
   output logic              sbox_we,
   output logic [BYTE_W-1:0] sbox_wdata,
   input  logic [BYTE_W-1:0] sbox_rdata,
   input  logic              cipher_valid,
   input  logic [BYTE_W-1:0] cipher_data,
   output logic              cipher_ready,
   output logic              plain_valid,
   output logic [BYTE_W-1:0] plain_data,
   input  logic              plain_ready
);

   prga_state_t       state_q;
   logic [BYTE_W-1:0] j_q, si_q, sj_q, k_q;
   logic [LEN_W-1:0]  rem_q;

   logic              busy_q, done_q, i_advance_q, sbox_we_q, cipher_ready_q, plain_valid_q;
   logic [ADDR_W-1:0] addr_q;
   logic              addr_sel_i_q;
   logic [BYTE_W-1:0] sbox_wdata_q, plain_data_q;

   // Sequencer: every output register is loaded with the value for the state being entered.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q        <= PRGA_IDLE;
         j_q            <= '0;
         si_q           <= '0;
         sj_q           <= '0;
         k_q            <= '0;
         rem_q          <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         i_advance_q    <= 1'b0;
         sbox_we_q      <= 1'b0;
         sbox_wdata_q   <= '0;
         addr_q         <= '0;
         addr_sel_i_q   <= 1'b0;
         cipher_ready_q <= 1'b0;
         plain_valid_q  <= 1'b0;
         plain_data_q   <= '0;
      end else begin
         done_q         <= 1'b0;
         i_advance_q    <= 1'b0;
         sbox_we_q      <= 1'b0;
         sbox_wdata_q   <= '0;
         addr_q         <= '0;
         addr_sel_i_q   <= 1'b0;
         cipher_ready_q <= 1'b0;

         case (state_q)
            PRGA_IDLE: begin
               if (start) begin
                  rem_q  <= msg_len;
                  j_q    <= '0;
                  busy_q <= 1'b1;
                  if (msg_len == '0) begin
                     state_q <= PRGA_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q     <= PRGA_ADV;
                     i_advance_q <= 1'b1;
                  end
               end
            end
            PRGA_ADV: begin
               // i_val is the advanced index once RD_SI is reached
               state_q      <= PRGA_RD_SI;
               addr_sel_i_q <= 1'b1;
            end
            PRGA_RD_SI: state_q <= PRGA_LD_SI;
            PRGA_LD_SI: begin
               si_q    <= sbox_rdata;
               j_q     <= j_q + sbox_rdata;
               addr_q  <= j_q + sbox_rdata;
               state_q <= PRGA_RD_SJ;
            end
            PRGA_RD_SJ: state_q <= PRGA_LD_SJ;
            PRGA_LD_SJ: begin
               sj_q         <= sbox_rdata;
               addr_sel_i_q <= 1'b1;
               sbox_we_q    <= 1'b1;
               sbox_wdata_q <= sbox_rdata;
               state_q      <= PRGA_WR_I;
            end
            PRGA_WR_I: begin
               addr_q       <= j_q;
               sbox_we_q    <= 1'b1;
               sbox_wdata_q <= si_q;
               state_q      <= PRGA_WR_J;
            end
            PRGA_WR_J: begin
               addr_q  <= si_q + sj_q;
               state_q <= PRGA_RD_K;
            end
            PRGA_RD_K: state_q <= PRGA_LD_K;
            PRGA_LD_K: begin
               k_q            <= sbox_rdata;
               cipher_ready_q <= 1'b1;
               state_q        <= PRGA_XFER;
            end
            PRGA_XFER: begin
               if (cipher_valid) begin
                  plain_data_q  <= cipher_data ^ k_q;
                  plain_valid_q <= 1'b1;
                  rem_q         <= rem_q - LEN_W'(1);
                  state_q       <= PRGA_HOLD;
               end else begin
                  cipher_ready_q <= 1'b1;
               end
            end
            PRGA_HOLD: begin
               if (plain_ready) begin
                  plain_valid_q <= 1'b0;
                  if (rem_q == '0) begin
                     state_q <= PRGA_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q     <= PRGA_ADV;
                     i_advance_q <= 1'b1;
                  end
               end
            end
            PRGA_DONE: begin
               busy_q  <= 1'b0;
               state_q <= PRGA_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= PRGA_IDLE;
            end
         endcase
      end
   end

   // Counter clear must land on the start edge so the first ADV yields i=1.
   assign i_clear = (state_q == PRGA_IDLE) && start;

   // Index-addressed accesses take the live counter value through a registered select.
   assign sbox_addr = addr_sel_i_q ? i_val : addr_q;

   assign busy         = busy_q;
   assign done         = done_q;
   assign i_advance    = i_advance_q;
   assign sbox_we      = sbox_we_q;
   assign sbox_wdata   = sbox_wdata_q;
   assign cipher_ready = cipher_ready_q;
   assign plain_valid  = plain_valid_q;
   assign plain_data   = plain_data_q;

endmodule

// File: tb/tb_rc4_prga_engine.sv
// Directed bench for rc4_prga_engine with behavioural i counter and S-box SRAM.
module tb_rc4_prga_engine;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        start;
   logic [15:0] msg_len;
   logic        busy, done, i_advance, i_clear, sbox_we, cipher_ready, plain_valid;
   logic [7:0]  i_cnt, sbox_addr, sbox_wdata, sbox_rdata, plain_data;
   logic        cipher_valid, plain_ready;
   logic [7:0]  cipher_data;

   int n_checks = 0;
   int n_errors = 0;

   // counters kept by the monitor, read as deltas by the tests
   int adv_cnt = 0, clr_cnt = 0, done_cnt = 0, acc_cnt = 0;
   logic wrap_seen = 1'b0;

   logic [7:0] sram [256];
   logic       bl_we = 1'b0;
   logic [7:0] bl_addr = 8'd0, bl_data = 8'd0;

   logic [7:0] s_init [256];
   logic [7:0] ref_s  [256];
   logic [7:0] ref_i, ref_j;
   logic [7:0] cin  [512];
   logic [7:0] pexp [512];

   always #5 clk = ~clk;

   rc4_prga_engine #(.LEN_W(16)) dut (
      .clk(clk), .n_rst(n_rst), .start(start), .msg_len(msg_len),
      .busy(busy), .done(done), .i_val(i_cnt), .i_advance(i_advance), .i_clear(i_clear),
      .sbox_addr(sbox_addr), .sbox_we(sbox_we), .sbox_wdata(sbox_wdata), .sbox_rdata(sbox_rdata),
      .cipher_valid(cipher_valid), .cipher_data(cipher_data), .cipher_ready(cipher_ready),
      .plain_valid(plain_valid), .plain_data(plain_data), .plain_ready(plain_ready)
   );

   // external i-index counter
   always @(posedge clk or negedge n_rst) begin
      if (!n_rst)         i_cnt <= 8'd0;
      else if (i_clear)   i_cnt <= 8'd0;
      else if (i_advance) i_cnt <= i_cnt + 8'd1;
   end

   // S-box SRAM, synchronous read; bench loads through a second write path
   always @(posedge clk) begin
      if (sbox_we)    sram[sbox_addr] <= sbox_wdata;
      else if (bl_we) sram[bl_addr]   <= bl_data;
      sbox_rdata <= sram[sbox_addr];
   end

   always @(posedge clk) begin
      if (i_advance) adv_cnt <= adv_cnt + 1;
      if (i_clear)   clr_cnt <= clr_cnt + 1;
      if (done)      done_cnt <= done_cnt + 1;
      if (sbox_we || sbox_addr != 8'd0) acc_cnt <= acc_cnt + 1;
      if (i_advance && i_cnt == 8'd255) wrap_seen <= 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_identity();
      for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
   endtask

   task automatic ksa3(input logic [7:0] k0, input logic [7:0] k1, input logic [7:0] k2);
      logic [7:0] kk [3];
      logic [7:0] j, t;
      kk[0] = k0; kk[1] = k1; kk[2] = k2;
      set_identity();
      j = 8'd0;
      for (int x = 0; x < 256; x++) begin
         j = j + s_init[x] + kk[x % 3];
         t = s_init[x]; s_init[x] = s_init[j]; s_init[j] = t;
      end
   endtask

   task automatic shuffle();
      logic [7:0] t;
      int r;
      set_identity();
      for (int x = 255; x > 0; x--) begin
         r = int'($urandom_range(x, 0));
         t = s_init[x]; s_init[x] = s_init[r]; s_init[r] = t;
      end
   endtask

   // copy s_init into the SRAM and the reference model
   task automatic load_sbox();
      for (int x = 0; x < 256; x++) begin
         bl_we = 1'b1; bl_addr = 8'(x); bl_data = s_init[x];
         ref_s[x] = s_init[x];
         tick();
      end
      bl_we = 1'b0;
      ref_i = 8'd0; ref_j = 8'd0;
   endtask

   task automatic ref_next(output logic [7:0] k);
      logic [7:0] t;
      ref_i = ref_i + 8'd1;
      ref_j = ref_j + ref_s[ref_i];
      t = ref_s[ref_i]; ref_s[ref_i] = ref_s[ref_j]; ref_s[ref_j] = t;
      t = ref_s[ref_i] + ref_s[ref_j];
      k = ref_s[t];
   endtask

   task automatic run_msg(input string tag, input int n, input bit stall, input bit extra_start);
      int a0, c0, d0, e0, serr;
      bit ok;
      a0 = adv_cnt; c0 = clr_cnt; d0 = done_cnt; e0 = acc_cnt;
      msg_len = 16'(n);
      start = 1'b1;
      tick();
      start = 1'b0;
      if (extra_start) begin
         start = 1'b1; msg_len = 16'd7;
         tick(); tick();
         start = 1'b0; msg_len = 16'(n);
      end
      for (int b = 0; b < n; b++) begin
         serr = 0;
         if (stall) begin
            repeat (3) begin
               tick();
               if (cipher_ready && sbox_we) serr++;
            end
         end
         cipher_valid = 1'b1; cipher_data = cin[b];
         ok = 1'b0;
         for (int c = 0; c < 40 && !ok; c++) begin
            if (cipher_ready) ok = 1'b1;
            tick();
         end
         cipher_valid = 1'b0;
         if (!ok) begin
            chk($sformatf("%s_cipher_timeout%0d", tag, b), 32'd0, 32'd1);
            return;
         end
         chk($sformatf("%s_pv%0d", tag, b), 32'(plain_valid), 32'd1);
         chk($sformatf("%s_pd%0d", tag, b), 32'(plain_data), 32'(pexp[b]));
         if (stall) begin
            repeat (5) begin
               tick();
               if (plain_valid !== 1'b1 || plain_data !== pexp[b] || sbox_we !== 1'b0 ||
                   cipher_ready !== 1'b0) serr++;
            end
            chk($sformatf("%s_stall%0d", tag, b), 32'(serr), 32'd0);
         end
         plain_ready = 1'b1;
         tick();
         plain_ready = 1'b0;
         chk($sformatf("%s_pv_drop%0d", tag, b), 32'(plain_valid), 32'd0);
      end
      chk({tag, "_done"}, {30'd0, busy, done}, 32'd3);
      tick();
      chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
      chk({tag, "_adv_cnt"}, 32'(adv_cnt - a0), 32'(n));
      chk({tag, "_clr_cnt"}, 32'(clr_cnt - c0), 32'd1);
      chk({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
      if (n == 0) chk({tag, "_no_sbox"}, 32'(acc_cnt - e0), 32'd0);
   endtask

   task automatic test_one(input string tag);
      int diff;
      cin[0] = 8'h00; pexp[0] = 8'h02;
      run_msg(tag, 1, 1'b0, 1'b0);
      diff = 0;
      for (int x = 0; x < 256; x++) if (sram[x] !== 8'(x)) diff++;
      chk({tag, "_sbox_same"}, 32'(diff), 32'd0);
   endtask

   function automatic logic [30:0] outs();
      return {busy, done, i_advance, i_clear, sbox_addr, sbox_we, sbox_wdata,
              cipher_ready, plain_valid, plain_data};
   endfunction

   initial begin
      logic [7:0] k;
      logic [7:0] ct [9];
      logic [7:0] pt [9];
      bit ok;
      ct[0]=8'hBB; ct[1]=8'hF3; ct[2]=8'h16; ct[3]=8'hE8; ct[4]=8'hD9;
      ct[5]=8'h40; ct[6]=8'hAF; ct[7]=8'h0A; ct[8]=8'hD3;
      pt[0]=8'h50; pt[1]=8'h6C; pt[2]=8'h61; pt[3]=8'h69; pt[4]=8'h6E;
      pt[5]=8'h74; pt[6]=8'h65; pt[7]=8'h78; pt[8]=8'h74;

      n_rst = 1'b0; start = 1'b0; msg_len = 16'd0;
      cipher_valid = 1'b0; cipher_data = 8'd0; plain_ready = 1'b0;
      repeat (3) tick();
      chk("reset_outputs", 32'(outs()), 32'd0);
      n_rst = 1'b1;
      tick();

      // 1: identity S-box, one byte
      set_identity(); load_sbox();
      test_one("t1");

      // 2: key "Key", known plaintext
      ksa3(8'h4B, 8'h65, 8'h79); load_sbox();
      for (int b = 0; b < 9; b++) begin cin[b] = ct[b]; pexp[b] = pt[b]; end
      run_msg("t2", 9, 1'b0, 1'b0);

      // 3: 300 bytes on a random S-box against the reference model
      shuffle(); load_sbox();
      for (int b = 0; b < 300; b++) begin
         ref_next(k);
         cin[b] = 8'($urandom);
         pexp[b] = cin[b] ^ k;
      end
      run_msg("t3", 300, 1'b0, 1'b0);
      chk("t3_i_wrapped", 32'(wrap_seen), 32'd1);

      // 4: stalls on both streams, identity keystream 02 05 07 0D
      set_identity(); load_sbox();
      cin[0]=8'hA0; pexp[0]=8'hA2;
      cin[1]=8'h5A; pexp[1]=8'h5F;
      cin[2]=8'hFF; pexp[2]=8'hF8;
      cin[3]=8'h3C; pexp[3]=8'h31;
      run_msg("t4", 4, 1'b1, 1'b0);

      // 5: empty message, then start pulsed while busy
      run_msg("t5a", 0, 1'b0, 1'b0);
      set_identity(); load_sbox();
      cin[0] = 8'h10; pexp[0] = 8'h12;
      run_msg("t5b", 1, 1'b0, 1'b1);
      repeat (3) tick();
      chk("t5_stay_idle", {30'd0, busy, done}, 32'd0);

      // 6: async reset while in WR_J
      msg_len = 16'd1; start = 1'b1;
      tick();
      start = 1'b0;
      ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin
         if (sbox_we) ok = 1'b1;
         else tick();
      end
      chk("t6_reach_wr_i", 32'(ok), 32'd1);
      tick();
      chk("t6_in_wr_j", {23'd0, sbox_we, sbox_addr}, {23'd0, 1'b1, 8'd1});
      n_rst = 1'b0;
      #1;
      chk("t6_reset_outputs", 32'(outs()), 32'd0);
      repeat (2) @(posedge clk);
      #1 n_rst = 1'b1;
      tick();
      set_identity(); load_sbox();
      test_one("t6");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
